vliw_bundle_ctrl: RTL and testbench

- Parametrised, registered control decoder for an N-wide VLIW bundle.
- Decodes NUM_R ALU-slot opcodes and NUM_S memory/control-slot opcodes per bundle into per-slot control strobes.
- Output is held in a one-entry pipeline register with valid/ready handshakes on both sides.
- Detects illegal opcodes and multiple control transfers in one bundle, squashes the faulting bundle, and halts issue until software/trap logic clears it.
- Sits between fetch and the register-read stage.

---
 rtl/vliw_ctrl_pkg.sv | 33 +++
 rtl/vliw_slot_decode.sv | 41 ++++
 rtl/vliw_bundle_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_vliw_bundle_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vliw_ctrl_pkg.sv
// Shared opcode map, exception-cause bit positions, slot control struct and
// the two-state issue FSM type for the VLIW bundle decoder.
package vliw_ctrl_pkg;

  localparam logic [4:0] OP_NOP    = 5'b00000;
  localparam logic [4:0] OP_ADD    = 5'b00011;
  localparam logic [4:0] OP_SUB    = 5'b01000;
  localparam logic [4:0] OP_LOAD   = 5'b01010;
  localparam logic [4:0] OP_STORE  = 5'b01011;
  localparam logic [4:0] OP_JUMP   = 5'b11100;
  localparam logic [4:0] OP_BRANCH = 5'b11010;

  localparam int EXC_ILL_S    = 0;
  localparam int EXC_ILL_R    = 1;
  localparam int EXC_MULTI_CT = 2;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_e;

  typedef struct packed {
    logic alu_op;
    logic src_a;
    logic src_b;
    logic regwrite;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump;
  } slot_ctrl_t;

endpackage

// File: rtl/vliw_slot_decode.sv
// Combinational decoder for one bundle slot; IS_S picks the memory/control
// table, otherwise the ALU table. Unknown codes raise illegal with all strobes 0.
module vliw_slot_decode
  import vliw_ctrl_pkg::*;
#(
  parameter bit IS_S = 1'b0,
  parameter int OP_W = 5
) (
  input  logic [OP_W-1:0] opcode,
  output slot_ctrl_t      ctrl,
  output logic            illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    if (IS_S) begin
      case (opcode)
        OP_W'(OP_NOP):    ;
        OP_W'(OP_LOAD):   begin ctrl.regwrite = 1'b1; ctrl.mem_read = 1'b1; end
        OP_W'(OP_STORE):  ctrl.mem_write = 1'b1;
        OP_W'(OP_JUMP):   ctrl.jump = 1'b1;
        OP_W'(OP_BRANCH): ctrl.branch = 1'b1;
        default:          illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OP_W'(OP_NOP): ;
        OP_W'(OP_ADD): ctrl.regwrite = 1'b1;
        OP_W'(OP_SUB): begin
          ctrl.alu_op   = 1'b1;
          ctrl.src_a    = 1'b1;
          ctrl.src_b    = 1'b1;
          ctrl.regwrite = 1'b1;
        end
        default:       illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/vliw_bundle_ctrl.sv
// Registered control decoder for an N-wide VLIW bundle with a one-entry output
// stage, fault squashing and a RUN/HALT issue FSM cleared by exc_clear.
module vliw_bundle_ctrl
  import vliw_ctrl_pkg::*;
#(
  parameter int NUM_R = 2,
  parameter int NUM_S = 2,
  parameter int OP_W  = 5,
  localparam int CS_W = (NUM_S > 1) ? $clog2(NUM_S) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUM_R*OP_W-1:0] r_opcode,
  input  logic [NUM_S*OP_W-1:0] s_opcode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_R-1:0]   alu_op,
  output logic [NUM_R-1:0]   alu_src_a,
  output logic [NUM_R-1:0]   alu_src_b,
  output logic [NUM_R-1:0]   r_regwrite,
  output logic [NUM_S-1:0]   s_regwrite,
  output logic [NUM_S-1:0]   mem_read,
  output logic [NUM_S-1:0]   mem_write,
  output logic               branch,
  output logic               jump,
  output logic [CS_W-1:0]    ctrl_slot,
  output logic               pc_write,
  output logic               exception,
  output logic [2:0]         exc_cause,
  input  logic               exc_clear,
  output state_e             dbg_state
);

  // Handshake: a bundle moves on in_valid && in_ready (upstream) and
  // out_valid && out_ready (downstream); the output register holds otherwise.

  slot_ctrl_t       r_dec [NUM_R];
  slot_ctrl_t       s_dec [NUM_S];
  logic [NUM_R-1:0] r_ill;
  logic [NUM_S-1:0] s_ill;

  for (genvar gr = 0; gr < NUM_R; gr++) begin : g_r
    vliw_slot_decode #(.IS_S(1'b0), .OP_W(OP_W)) u_dec (
      .opcode  (r_opcode[gr*OP_W +: OP_W]),
      .ctrl    (r_dec[gr]),
      .illegal (r_ill[gr])
    );
  end

  for (genvar gs = 0; gs < NUM_S; gs++) begin : g_s
    vliw_slot_decode #(.IS_S(1'b1), .OP_W(OP_W)) u_dec (
      .opcode  (s_opcode[gs*OP_W +: OP_W]),
      .ctrl    (s_dec[gs]),
      .illegal (s_ill[gs])
    );
  end

  logic [NUM_R-1:0] dec_alu_op, dec_src_a, dec_src_b, dec_rw;
  logic [NUM_S-1:0] dec_srw, dec_mr, dec_mw;
  logic             dec_br, dec_jp, seen_ct, multi_ct;
  logic [CS_W-1:0]  dec_cs;
  logic [NUM_R-1:0] unused_r;
  logic [NUM_S-1:0] unused_s;
  logic [2:0]       cause;

  always_comb begin
    dec_alu_op = '0;
    dec_src_a  = '0;
    dec_src_b  = '0;
    dec_rw     = '0;
    dec_srw    = '0;
    dec_mr     = '0;
    dec_mw     = '0;
    dec_br     = 1'b0;
    dec_jp     = 1'b0;
    seen_ct    = 1'b0;
    multi_ct   = 1'b0;
    dec_cs     = '0;
    unused_r   = '0;
    unused_s   = '0;
    for (int i = 0; i < NUM_R; i++) begin
      dec_alu_op[i] = r_dec[i].alu_op;
      dec_src_a[i]  = r_dec[i].src_a;
      dec_src_b[i]  = r_dec[i].src_b;
      dec_rw[i]     = r_dec[i].regwrite;
      unused_r[i]   = ^{r_dec[i].mem_read, r_dec[i].mem_write, r_dec[i].branch, r_dec[i].jump};
    end
    // ctrl_slot reports the lowest slot; any second transfer is a fault.
    for (int i = 0; i < NUM_S; i++) begin
      dec_srw[i]  = s_dec[i].regwrite;
      dec_mr[i]   = s_dec[i].mem_read;
      dec_mw[i]   = s_dec[i].mem_write;
      unused_s[i] = ^{s_dec[i].alu_op, s_dec[i].src_a, s_dec[i].src_b};
      dec_br      = dec_br | s_dec[i].branch;
      dec_jp      = dec_jp | s_dec[i].jump;
      if (s_dec[i].branch || s_dec[i].jump) begin
        if (seen_ct) multi_ct = 1'b1;
        else         dec_cs   = CS_W'(i);
        seen_ct = 1'b1;
      end
    end
    cause               = '0;
    cause[EXC_ILL_S]    = |s_ill;
    cause[EXC_ILL_R]    = |r_ill;
    cause[EXC_MULTI_CT] = multi_ct;
  end

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d, exc_q, exc_d;
  logic [2:0]       exc_cause_q, exc_cause_d;
  logic [NUM_R-1:0] alu_op_q, alu_op_d, src_a_q, src_a_d, src_b_q, src_b_d, r_rw_q, r_rw_d;
  logic [NUM_S-1:0] s_rw_q, s_rw_d, mr_q, mr_d, mw_q, mw_d;
  logic             br_q, br_d, jp_q, jp_d;
  logic [CS_W-1:0]  cs_q, cs_d;
  logic             accept, fault;

  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign pc_write = accept;
  assign fault    = |cause;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    exc_d       = exc_q;
    exc_cause_d = exc_cause_q;
    alu_op_d    = alu_op_q;
    src_a_d     = src_a_q;
    src_b_d     = src_b_q;
    r_rw_d      = r_rw_q;
    s_rw_d      = s_rw_q;
    mr_d        = mr_q;
    mw_d        = mw_q;
    br_d        = br_q;
    jp_d        = jp_q;
    cs_d        = cs_q;
    if (accept) begin
      out_valid_d = 1'b1;
      // A faulting bundle still occupies the stage but carries no side effects.
      alu_op_d = fault ? '0 : dec_alu_op;
      src_a_d  = fault ? '0 : dec_src_a;
      src_b_d  = fault ? '0 : dec_src_b;
      r_rw_d   = fault ? '0 : dec_rw;
      s_rw_d   = fault ? '0 : dec_srw;
      mr_d     = fault ? '0 : dec_mr;
      mw_d     = fault ? '0 : dec_mw;
      br_d     = fault ? 1'b0 : dec_br;
      jp_d     = fault ? 1'b0 : dec_jp;
      cs_d     = fault ? '0 : dec_cs;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      RUN: if (accept && fault) begin
        state_d     = HALT;
        exc_d       = 1'b1;
        exc_cause_d = cause;
      end
      HALT: if (exc_clear) begin
        state_d     = RUN;
        exc_d       = 1'b0;
        exc_cause_d = '0;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      out_valid_q <= 1'b0;
      exc_q       <= 1'b0;
      exc_cause_q <= '0;
      alu_op_q    <= '0;
      src_a_q     <= '0;
      src_b_q     <= '0;
      r_rw_q      <= '0;
      s_rw_q      <= '0;
      mr_q        <= '0;
      mw_q        <= '0;
      br_q        <= 1'b0;
      jp_q        <= 1'b0;
      cs_q        <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      exc_q       <= exc_d;
      exc_cause_q <= exc_cause_d;
      alu_op_q    <= alu_op_d;
      src_a_q     <= src_a_d;
      src_b_q     <= src_b_d;
      r_rw_q      <= r_rw_d;
      s_rw_q      <= s_rw_d;
      mr_q        <= mr_d;
      mw_q        <= mw_d;
      br_q        <= br_d;
      jp_q        <= jp_d;
      cs_q        <= cs_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_op     = alu_op_q;
  assign alu_src_a  = src_a_q;
  assign alu_src_b  = src_b_q;
  assign r_regwrite = r_rw_q;
  assign s_regwrite = s_rw_q;
  assign mem_read   = mr_q;
  assign mem_write  = mw_q;
  assign branch     = br_q;
  assign jump       = jp_q;
  assign ctrl_slot  = cs_q;
  assign exception  = exc_q;
  assign exc_cause  = exc_cause_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_vliw_bundle_ctrl.sv
// Directed and randomized bench for vliw_bundle_ctrl against a bundle-level
// reference model of decode, squash, halt and output-stage behaviour.
module tb_vliw_bundle_ctrl;
  import vliw_ctrl_pkg::*;

  localparam int NUM_R = 2;
  localparam int NUM_S = 2;
  localparam int OP_W  = 5;
  localparam int CS_W  = 1;

  localparam logic [4:0] R_NOP = 5'b00000, R_ADD = 5'b00011, R_SUB = 5'b01000;
  localparam logic [4:0] S_NOP = 5'b00000, S_LOAD = 5'b01010, S_STORE = 5'b01011;
  localparam logic [4:0] S_JUMP = 5'b11100, S_BRANCH = 5'b11010;

  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, out_valid, out_ready, exc_clear;
  logic [NUM_R*OP_W-1:0] r_opcode;
  logic [NUM_S*OP_W-1:0] s_opcode;
  logic [NUM_R-1:0] alu_op, alu_src_a, alu_src_b, r_regwrite;
  logic [NUM_S-1:0] s_regwrite, mem_read, mem_write;
  logic branch, jump, pc_write, exception;
  logic [CS_W-1:0] ctrl_slot;
  logic [2:0] exc_cause;
  state_e dbg_state;

  always #5 clk = ~clk;

  vliw_bundle_ctrl #(.NUM_R(NUM_R), .NUM_S(NUM_S), .OP_W(OP_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .r_opcode(r_opcode), .s_opcode(s_opcode), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .r_regwrite(r_regwrite), .s_regwrite(s_regwrite),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
    .ctrl_slot(ctrl_slot), .pc_write(pc_write), .exception(exception),
    .exc_cause(exc_cause), .exc_clear(exc_clear), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: what the decoded output stage should hold.
  logic             m_halt, m_ov, m_br, m_jp;
  logic [2:0]       m_cause;
  logic [NUM_R-1:0] m_aop, m_sa, m_sb, m_rw;
  logic [NUM_S-1:0] m_srw, m_mr, m_mw;
  int               m_cs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halt = 0; m_ov = 0; m_br = 0; m_jp = 0; m_cause = 0; m_cs = 0;
    m_aop = 0; m_sa = 0; m_sb = 0; m_rw = 0; m_srw = 0; m_mr = 0; m_mw = 0;
  endtask

  function automatic logic exp_in_ready();
    return !m_halt && (!m_ov || out_ready);
  endfunction

  task automatic check_outputs(input string where);
    chk({where, ".in_ready"},   32'(in_ready),   32'(exp_in_ready()));
    chk({where, ".pc_write"},   32'(pc_write),   32'(in_valid && exp_in_ready()));
    chk({where, ".out_valid"},  32'(out_valid),  32'(m_ov));
    chk({where, ".alu_op"},     32'(alu_op),     32'(m_aop));
    chk({where, ".alu_src_a"},  32'(alu_src_a),  32'(m_sa));
    chk({where, ".alu_src_b"},  32'(alu_src_b),  32'(m_sb));
    chk({where, ".r_regwrite"}, 32'(r_regwrite), 32'(m_rw));
    chk({where, ".s_regwrite"}, 32'(s_regwrite), 32'(m_srw));
    chk({where, ".mem_read"},   32'(mem_read),   32'(m_mr));
    chk({where, ".mem_write"},  32'(mem_write),  32'(m_mw));
    chk({where, ".branch"},     32'(branch),     32'(m_br));
    chk({where, ".jump"},       32'(jump),       32'(m_jp));
    chk({where, ".ctrl_slot"},  32'(ctrl_slot),  32'(m_cs));
    chk({where, ".exception"},  32'(exception),  32'(m_halt));
    chk({where, ".exc_cause"},  32'(exc_cause),  32'(m_cause));
    chk({where, ".dbg_state"},  32'(dbg_state),  32'(m_halt ? HALT : RUN));
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic acc;
    logic [NUM_R-1:0] aop, sa, sb, rw;
    logic [NUM_S-1:0] srw, mr, mw;
    logic br, jp, ill_r, ill_s;
    int n_ct, cs;
    logic [4:0] op;
    logic [2:0] cause;
    acc = in_valid && exp_in_ready();
    aop = 0; sa = 0; sb = 0; rw = 0; srw = 0; mr = 0; mw = 0;
    br = 0; jp = 0; ill_r = 0; ill_s = 0; n_ct = 0; cs = 0;
    for (int i = 0; i < NUM_R; i++) begin
      op = r_opcode[i*OP_W +: OP_W];
      if (op == R_ADD) rw[i] = 1;
      else if (op == R_SUB) begin aop[i] = 1; sa[i] = 1; sb[i] = 1; rw[i] = 1; end
      else if (op != R_NOP) ill_r = 1;
    end
    for (int i = 0; i < NUM_S; i++) begin
      op = s_opcode[i*OP_W +: OP_W];
      if (op == S_LOAD) begin srw[i] = 1; mr[i] = 1; end
      else if (op == S_STORE) mw[i] = 1;
      else if (op == S_JUMP || op == S_BRANCH) begin
        if (n_ct == 0) cs = i;
        n_ct++;
        if (op == S_JUMP) jp = 1; else br = 1;
      end
      else if (op != S_NOP) ill_s = 1;
    end
    cause = {n_ct > 1, ill_r, ill_s};
    if (m_halt) begin
      if (exc_clear) begin m_halt = 0; m_cause = 0; end
    end else if (acc && cause != 0) begin
      m_halt = 1; m_cause = cause;
    end
    if (acc) begin
      m_ov = 1;
      if (cause != 0) begin
        m_aop = 0; m_sa = 0; m_sb = 0; m_rw = 0; m_srw = 0; m_mr = 0; m_mw = 0;
        m_br = 0; m_jp = 0; m_cs = 0;
      end else begin
        m_aop = aop; m_sa = sa; m_sb = sb; m_rw = rw; m_srw = srw; m_mr = mr; m_mw = mw;
        m_br = br; m_jp = jp; m_cs = cs;
      end
    end else if (out_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic drive(input logic v, input logic [9:0] r, input logic [9:0] s,
                       input logic ordy, input logic clr);
    in_valid = v; r_opcode = r; s_opcode = s; out_ready = ordy; exc_clear = clr;
  endtask

  task automatic step(input string where);
    @(negedge clk);
    check_outputs(where);
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] rand_r();
    case ($urandom_range(0, 15))
      0: return 5'($urandom_range(0, 31));
      1, 2, 3: return R_NOP;
      4, 5, 6, 7, 8, 9: return R_ADD;
      default: return R_SUB;
    endcase
  endfunction

  function automatic logic [4:0] rand_s();
    case ($urandom_range(0, 15))
      0: return 5'($urandom_range(0, 31));
      1, 2, 3: return S_NOP;
      4, 5, 6, 7: return S_LOAD;
      8, 9, 10, 11: return S_STORE;
      12, 13: return S_BRANCH;
      default: return S_JUMP;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(0, '0, '0, 0, 0);
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Basic decode with a mix of ALU and memory slots
    drive(1, {R_ADD, R_SUB}, {S_STORE, S_LOAD}, 1, 0);
    step("accept1");
    // Backpressure: held output, no accept, then accept when ready rises
    drive(1, {R_SUB, R_ADD}, {S_NOP, S_LOAD}, 0, 0);
    step("bp1");
    step("bp2");
    step("bp3");
    out_ready = 1;
    step("bp_release");
    // Single branch in slot 1
    drive(1, {R_NOP, R_ADD}, {S_BRANCH, S_NOP}, 1, 0);
    step("branch_s1");
    drive(0, '0, '0, 1, 0);
    step("drain1");
    // Two control transfers: squash and halt
    drive(1, {R_ADD, R_ADD}, {S_JUMP, S_BRANCH}, 1, 0);
    step("multi_ct");
    drive(1, {R_ADD, R_SUB}, {S_LOAD, S_STORE}, 1, 0);
    step("halt1");
    step("halt2");
    exc_clear = 1;
    step("clear");
    exc_clear = 0;
    step("after_clear");
    // Illegal R and S opcodes with exc_clear held during the faulting accept
    drive(1, {R_ADD, 5'b11111}, {5'b00111, S_NOP}, 1, 1);
    step("illegal_rs");
    exc_clear = 0;
    out_ready = 0;
    step("halt_hold");
    // Asynchronous reset while halted with a held bundle
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, '0, '0, 1, 0);
    step("post_rst");

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, {rand_r(), rand_r()}, {rand_s(), rand_s()},
            $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
